fir_seq_ctrl: RTL and testbench

Sequencer and coefficient manager for the FIRROOT datapath. Holds a double-buffered 7-tap coefficient bank (shadow written over a simple config port, active driven onto B0..B6), accepts one block of input samples over a valid/ready stream and drives them onto the filter's Data_i. It then flushes the filter tail with zeros and tags which FIRout/ROOTout cycles carry valid block outputs. Sits directly in front of FIRROOT, between the sample source/register interface and the filter.

---
 rtl/fir_pkg.sv | 15 +
 rtl/fir_seq_ctrl_if.sv | 17 +
 rtl/fir_coef_bank.sv | 37 +++
 rtl/fir_seq_ctrl.sv | 109 ++++++++++
 tb/tb_fir_seq_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared constants and types for the FIRROOT sequencer: block geometry,
// controller states and the coefficient bank layout.
package fir_pkg;
  localparam int DW      = 8;
  localparam int NTAPS   = 7;
  localparam int LAT     = 2;
  localparam int BLK_LEN = 20;
  localparam int ADDR_W  = 3;
  localparam int SCNT_W  = $clog2(BLK_LEN + 1);
  localparam int FCNT_W  = $clog2(NTAPS - 1 + LAT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE} state_t;

  typedef logic [NTAPS-1:0][DW-1:0] coef_bank_t;
endpackage

// File: rtl/fir_seq_ctrl_if.sv
// Config port and sample stream between the register/sample source and
// the sequencer.
interface fir_seq_ctrl_if;
  import fir_pkg::*;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DW-1:0]     cfg_data;
  logic              cfg_commit;
  logic              s_valid;
  logic [DW-1:0]     s_data;
  logic              s_ready;

  modport master (output cfg_we, cfg_addr, cfg_data, cfg_commit, s_valid, s_data,
                  input  s_ready);
  modport slave  (input  cfg_we, cfg_addr, cfg_data, cfg_commit, s_valid, s_data,
                  output s_ready);
endinterface

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient bank: shadow is written freely, active only
// moves on a commit while idle or on the DONE->IDLE edge.
module fir_coef_bank
  import fir_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DW-1:0]     wdata,
  input  logic              commit,
  input  logic              st_idle,
  input  logic              st_done,
  output coef_bank_t        active
);
  coef_bank_t shadow;
  logic       commit_pending;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      shadow         <= '0;
      active         <= '0;
      commit_pending <= 1'b0;
    end else begin
      // active copies the pre-edge shadow, so a same-cycle write lands in shadow only
      if (we && (addr < ADDR_W'(NTAPS))) shadow[addr] <= wdata;
      if (st_idle) begin
        if (commit) active <= shadow;
      end else if (st_done) begin
        if (commit_pending || commit) active <= shadow;
        commit_pending <= 1'b0;
      end else if (commit) begin
        commit_pending <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/fir_seq_ctrl.sv
// Block sequencer in front of FIRROOT: feeds one block of samples, flushes
// the convolution tail and tags which filter outputs belong to the block.
module fir_seq_ctrl
  import fir_pkg::*;
(
  input  logic          Clk,
  input  logic          Rst,
  fir_seq_ctrl_if.slave bus,
  input  logic          start,
  output logic [DW-1:0] B0,
  output logic [DW-1:0] B1,
  output logic [DW-1:0] B2,
  output logic [DW-1:0] B3,
  output logic [DW-1:0] B4,
  output logic [DW-1:0] B5,
  output logic [DW-1:0] B6,
  output logic [DW-1:0] Data_o,
  output logic          out_valid,
  output logic          out_last,
  output logic          busy,
  output logic          done
);
  state_t            state;
  logic [SCNT_W-1:0] samp_cnt;
  logic [FCNT_W-1:0] flush_cnt;
  logic              s_ready_q;
  logic [LAT:0]      tag_pipe;
  logic [LAT:0]      last_pipe;
  coef_bank_t        active;
  logic              accept;

  assign accept      = bus.s_valid && s_ready_q;
  assign bus.s_ready = s_ready_q;
  assign out_valid   = tag_pipe[LAT];
  assign out_last    = last_pipe[LAT];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= ST_IDLE;
      samp_cnt  <= '0;
      flush_cnt <= '0;
      s_ready_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      Data_o    <= '0;
      tag_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      // stage 0 defaults to an untagged zero; the filter never stalls
      tag_pipe  <= {tag_pipe[LAT-1:0], 1'b0};
      last_pipe <= {last_pipe[LAT-1:0], 1'b0};
      Data_o    <= '0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          state     <= ST_RUN;
          samp_cnt  <= '0;
          flush_cnt <= '0;
          s_ready_q <= 1'b1;
          busy      <= 1'b1;
        end
        ST_RUN: if (accept) begin
          Data_o      <= bus.s_data;
          tag_pipe[0] <= 1'b1;
          samp_cnt    <= samp_cnt + SCNT_W'(1);
          if (samp_cnt == SCNT_W'(BLK_LEN - 1)) begin
            state     <= ST_FLUSH;
            s_ready_q <= 1'b0;
          end
        end
        ST_FLUSH: begin
          flush_cnt <= flush_cnt + FCNT_W'(1);
          // first NTAPS-1 zeros complete the convolution tail, the rest drain LAT
          if (flush_cnt < FCNT_W'(NTAPS - 1)) tag_pipe[0] <= 1'b1;
          if (flush_cnt == FCNT_W'(NTAPS - 2)) last_pipe[0] <= 1'b1;
          if (flush_cnt == FCNT_W'(NTAPS + LAT - 2)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fir_coef_bank u_bank (
    .Clk     (Clk),
    .Rst     (Rst),
    .we      (bus.cfg_we),
    .addr    (bus.cfg_addr),
    .wdata   (bus.cfg_data),
    .commit  (bus.cfg_commit),
    .st_idle (state == ST_IDLE),
    .st_done (state == ST_DONE),
    .active  (active)
  );

  assign B0 = active[0];
  assign B1 = active[1];
  assign B2 = active[2];
  assign B3 = active[3];
  assign B4 = active[4];
  assign B5 = active[5];
  assign B6 = active[6];
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Self-checking bench for fir_seq_ctrl: per-block expected streams are built
// from the block rules (accepts, tail, drain) and compared cycle by cycle.
module tb_fir_seq_ctrl;
  import fir_pkg::*;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          start;
  logic [DW-1:0] B0, B1, B2, B3, B4, B5, B6;
  logic [DW-1:0] Data_o;
  logic          out_valid, out_last, busy, done;

  fir_seq_ctrl_if bus();

  fir_seq_ctrl dut (
    .Clk(Clk), .Rst(Rst), .bus(bus), .start(start),
    .B0(B0), .B1(B1), .B2(B2), .B3(B3), .B4(B4), .B5(B5), .B6(B6),
    .Data_o(Data_o), .out_valid(out_valid), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  int         checks = 0;
  int         failures = 0;
  coef_bank_t bv;
  coef_bank_t sh_m, act_m;
  bit         pend;

  assign bv = {B6, B5, B4, B3, B2, B1, B0};

  // one config cycle while idle; model: commit takes pre-edge shadow
  task automatic idle_cfg(input bit we, input int addr, input int data, input bit commit);
    bus.cfg_we = we; bus.cfg_addr = addr[2:0]; bus.cfg_data = data[7:0]; bus.cfg_commit = commit;
    @(negedge Clk);
    bus.cfg_we = 1'b0; bus.cfg_commit = 1'b0;
    if (commit) act_m = sh_m;
    if (we && addr < NTAPS) sh_m[addr] = data[7:0];
  endtask

  // mode 0: s_valid always, data 1..N; mode 1: drop every third cycle;
  // mode 2: random valid/data plus stray start pulses while busy
  task automatic run_block(input int mode, input int commit_lbl, input bit start_cfg);
    logic [DW-1:0] exp_d [0:159];
    bit            exp_t [0:159];
    int            n_acc = 0, done_lbl = 1000, nvalid = 0;
    bit            fin = 0, rdy, v, exp_ov;
    logic [DW-1:0] d;
    for (int i = 0; i < 160; i++) begin exp_d[i] = '0; exp_t[i] = 0; end
    start = 1'b1;
    if (start_cfg) begin
      bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_data = 8'hA5; bus.cfg_commit = 1'b1;
      act_m = sh_m; sh_m[0] = 8'hA5;
    end
    @(negedge Clk);
    start = 1'b0; bus.cfg_we = 1'b0; bus.cfg_commit = 1'b0;
    for (int c = 1; c < 150; c++) begin
      rdy = (n_acc < BLK_LEN);
      exp_ov = (c > LAT) ? exp_t[c-LAT] : 1'b0;
      checks++; if (bus.s_ready !== rdy) begin failures++;
        $display("FAIL blk_s_ready c=%0d got=%b exp=%b", c, bus.s_ready, rdy); end
      checks++; if (Data_o !== exp_d[c]) begin failures++;
        $display("FAIL blk_data c=%0d got=%h exp=%h", c, Data_o, exp_d[c]); end
      checks++; if (out_valid !== exp_ov) begin failures++;
        $display("FAIL blk_out_valid c=%0d got=%b exp=%b", c, out_valid, exp_ov); end
      checks++; if (out_last !== (c == done_lbl)) begin failures++;
        $display("FAIL blk_out_last c=%0d got=%b exp=%b", c, out_last, c == done_lbl); end
      checks++; if (done !== (c == done_lbl)) begin failures++;
        $display("FAIL blk_done c=%0d got=%b exp=%b", c, done, c == done_lbl); end
      checks++; if (busy !== (c <= done_lbl)) begin failures++;
        $display("FAIL blk_busy c=%0d got=%b exp=%b", c, busy, c <= done_lbl); end
      checks++; if (bv !== act_m) begin failures++;
        $display("FAIL blk_coef c=%0d got=%h exp=%h", c, bv, act_m); end
      if (out_valid === 1'b1) nvalid++;
      if (c == done_lbl + 1) begin fin = 1; break; end
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 3 != 0) : ($urandom_range(0, 3) != 0 || c > 60);
      d = (mode == 0) ? 8'(n_acc + 1) : 8'($urandom_range(1, 255));
      bus.s_valid = v; bus.s_data = d;
      start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.cfg_commit = (c == commit_lbl);
      if (c == commit_lbl) pend = 1;
      if (v && rdy) begin
        n_acc++;
        exp_d[c+1] = d; exp_t[c+1] = 1;
        if (n_acc == BLK_LEN) begin
          for (int k = 2; k <= NTAPS; k++) exp_t[c+k] = 1;
          done_lbl = c + NTAPS + LAT;
        end
      end
      if (c == done_lbl && pend) begin act_m = sh_m; pend = 0; end
      @(negedge Clk);
    end
    bus.s_valid = 1'b0; start = 1'b0; bus.cfg_commit = 1'b0;
    checks++; if (!fin) begin failures++;
      $display("FAIL blk_timeout got=no_done exp=done_within_budget"); end
    checks++; if (nvalid != BLK_LEN + NTAPS - 1) begin failures++;
      $display("FAIL blk_valid_count got=%0d exp=%0d", nvalid, BLK_LEN + NTAPS - 1); end
  endtask

  task automatic test_reset_state();
    @(negedge Clk);
    checks++; if ({bus.s_ready, busy, done, out_valid, out_last, Data_o} !== '0) begin failures++;
      $display("FAIL reset_outputs got=%b exp=0", {bus.s_ready, busy, done, out_valid, out_last, Data_o}); end
    checks++; if (bv !== '0) begin failures++;
      $display("FAIL reset_coef got=%h exp=0", bv); end
    Rst = 1'b0;
    @(negedge Clk);
    checks++; if (busy !== 1'b0) begin failures++;
      $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_coef();
    for (int i = 0; i < NTAPS; i++) idle_cfg(1, i, i + 1, 0);
    checks++; if (bv !== act_m) begin failures++;
      $display("FAIL coef_no_commit got=%h exp=%h", bv, act_m); end
    idle_cfg(0, 0, 0, 1);
    checks++; if (bv !== act_m) begin failures++;
      $display("FAIL coef_commit got=%h exp=%h", bv, act_m); end
    checks++; if (B6 !== 8'd7 || B0 !== 8'd1) begin failures++;
      $display("FAIL coef_values got=B0:%0d,B6:%0d exp=B0:1,B6:7", B0, B6); end
    idle_cfg(1, 7, 8'h63, 0);
    idle_cfg(0, 0, 0, 1);
    checks++; if (bv !== act_m) begin failures++;
      $display("FAIL coef_bad_addr got=%h exp=%h", bv, act_m); end
  endtask

  task automatic test_full_block();
    run_block(0, -1, 0);
  endtask

  task automatic test_bubbles();
    run_block(1, -1, 0);
  endtask

  task automatic test_commit_busy();
    for (int i = 0; i < NTAPS; i++) idle_cfg(1, i, 5, 0);
    checks++; if (bv !== act_m) begin failures++;
      $display("FAIL cb_pre got=%h exp=%h", bv, act_m); end
    run_block(0, 5, 0);
    checks++; if (bv !== {NTAPS{8'd5}}) begin failures++;
      $display("FAIL cb_after got=%h exp=all_05", bv); end
  endtask

  task automatic test_start_commit();
    for (int i = 0; i < NTAPS; i++) idle_cfg(1, i, 8'h30 + i, 0);
    run_block(2, -1, 1);
    checks++; if (B0 !== 8'h30) begin failures++;
      $display("FAIL sc_old_tap0 got=%h exp=30", B0); end
    idle_cfg(0, 0, 0, 1);
    checks++; if (B0 !== 8'hA5 || bv !== act_m) begin failures++;
      $display("FAIL sc_shadow_tap0 got=%h exp=%h", bv, act_m); end
  endtask

  task automatic test_random();
    idle_cfg(1, 3, $urandom_range(0, 255), 0);
    run_block(2, 12, 0);
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0; bus.s_valid = 1'b1; bus.s_data = 8'h11;
    repeat (3) @(negedge Clk);
    bus.cfg_commit = 1'b1;
    @(negedge Clk);
    bus.cfg_commit = 1'b0;
    #2 Rst = 1'b1;
    #1;
    checks++; if ({bus.s_ready, busy, done, out_valid, out_last, Data_o} !== '0) begin failures++;
      $display("FAIL rst_mid_outputs got=%b exp=0", {bus.s_ready, busy, done, out_valid, out_last, Data_o}); end
    checks++; if (bv !== '0) begin failures++;
      $display("FAIL rst_mid_coef got=%h exp=0", bv); end
    sh_m = '0; act_m = '0; pend = 0;
    bus.s_valid = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checks++; if ({busy, done} !== 2'b00) begin failures++;
        $display("FAIL rst_mid_idle got=%b exp=00", {busy, done}); end
    end
    for (int i = 0; i < NTAPS; i++) idle_cfg(1, i, 9, 0);
    run_block(0, -1, 0);
    checks++; if (bv !== '0) begin failures++;
      $display("FAIL rst_pending_dropped got=%h exp=0", bv); end
  endtask

  initial begin
    Rst = 1'b1; start = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.cfg_commit = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0;
    sh_m = '0; act_m = '0; pend = 0;
    test_reset_state();
    test_coef();
    test_full_block();
    test_bubbles();
    test_commit_busy();
    test_start_commit();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
